plane_deserializer: RTL

PLANE_DESERIALIZER -- requirements
Module: plane_deserializer

---
 rtl/plane_deserializer_pkg.sv | 6 +
 rtl/plane_deserializer_if.sv | 18 +
 rtl/plane_deser_lane.sv | 19 +
 rtl/plane_deserializer.sv | 68 ++++++
 4 files changed

// File: rtl/plane_deserializer_pkg.sv
// plane_deserializer_pkg: shared video parameters and deserializer state encoding
package plane_deserializer_pkg;
    localparam int PLANES_DEF = 4;
    localparam int WIDTH_DEF  = 8;
    typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/plane_deserializer_if.sv
// plane_deserializer_if: pixel input and word output handshakes of the deserializer
interface plane_deserializer_if #(
    parameter int PLANES = plane_deserializer_pkg::PLANES_DEF,
    parameter int WIDTH  = plane_deserializer_pkg::WIDTH_DEF
);
    logic [PLANES-1:0]       pix_bit;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    flip;
    logic                    sync;
    logic [PLANES*WIDTH-1:0] out_word;
    logic                    out_valid;
    logic                    out_ready;
    modport master (output pix_bit, pix_valid, flip, sync, out_ready,
                    input  pix_ready, out_word, out_valid);
    modport slave  (input  pix_bit, pix_valid, flip, sync, out_ready,
                    output pix_ready, out_word, out_valid);
endinterface

// File: rtl/plane_deser_lane.sv
// plane_deser_lane: one bitplane assembly register shifting in either direction
module plane_deser_lane #(
    parameter int WIDTH = plane_deserializer_pkg::WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             dir,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shifted
);
    // dir=1 enters at the MSB so the first pixel ends up in bit 0
    assign shifted = dir ? {din, q[WIDTH-1:1]} : {q[WIDTH-2:0], din};

    always_ff @(posedge clock)
        q <= (reset || clear) ? '0 : load ? shifted : q;
endmodule

// File: rtl/plane_deserializer.sv
// plane_deserializer: gathers one bit per plane per pixel into WIDTH-bit plane words
module plane_deserializer
    import plane_deserializer_pkg::*;
#(
    parameter int PLANES = PLANES_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input logic clock,
    input logic reset,
    plane_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic                    flip_r, dir, accept, last, direct, xfer;
    logic [PLANES*WIDTH-1:0] asm_word, shf_word, out_word_q;
    logic                    out_valid_q;

    assign bus.pix_ready = state == FILL;
    assign bus.out_word  = out_word_q;
    assign bus.out_valid = out_valid_q;
    assign accept = bus.pix_valid && state == FILL && !bus.sync;
    assign last   = accept && cnt == CW'(WIDTH - 1);
    assign direct = last && (!out_valid_q || bus.out_ready);
    assign xfer   = state == HOLD && bus.out_ready && !bus.sync;
    // the direction latched on the first beat governs the rest of the word
    assign dir    = cnt == '0 ? bus.flip : flip_r;

    for (genvar p = 0; p < PLANES; p++) begin : g_lane
        plane_deser_lane #(.WIDTH(WIDTH)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .clear  (bus.sync),
            .load   (accept),
            .dir    (dir),
            .din    (bus.pix_bit[p]),
            .q      (asm_word[p*WIDTH +: WIDTH]),
            .shifted(shf_word[p*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        state_nxt = state;
        state_nxt = bus.sync ? FILL : (last && !direct) ? HOLD : xfer ? FILL : state;
    end

    always_ff @(posedge clock)
        state <= reset ? FILL : state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            flip_r      <= 1'b0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt    <= bus.sync ? '0 : accept ? (last ? '0 : cnt + 1'b1) : cnt;
            flip_r <= (accept && cnt == '0) ? bus.flip : flip_r;
            if (direct || xfer) begin
                out_word_q  <= direct ? shf_word : asm_word;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
